// File: rtl/jio_port.sv
// jio_port: device-side responder on the CPU IO bus.
// Decodes the OUT Addr device select, latches OUT Data bytes into a one-entry
// TX holding register and answers IN Data reads from a small RX FIFO that the
// board-side peripheral fills.
// Optional feature: define JIO_STATUS_EN to decode IN Addr as a status read
// {rx_nonempty, tx_valid, ovf, rx_full, 4'b0}; the read also clears ovf.
module jio_port #(
    parameter logic [7:0] DEV_ID   = 8'h00,
    parameter int          RX_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       io_s,
    input  logic       io_e,
    input  logic       io_da,
    input  logic       io_io,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       selected,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CNT_W = $clog2(RX_DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_DEPTH);

    logic             s_q;
    logic             e_q;
    logic             wake;
    logic             rd_q;
    logic [7:0]       dev_addr;
    logic             ovf;
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] rx_count;

    logic s_rise;
    logic e_fall;
    logic out_addr;
    logic out_data;
    logic tx_load;
    logic tx_drop;
    logic in_data;
    logic in_status;
    logic status_clr;
    logic rx_empty;
    logic rx_full;
    logic rx_push;
    logic rx_pop;

    // The wake flag masks the first edge after reset so a strobe that was
    // already high when reset released is captured into s_q, not acted on.
    assign s_rise   = io_s & ~s_q & ~wake;
    assign e_fall   = ~io_e & e_q;

    assign selected = (dev_addr == DEV_ID);
    assign out_addr = s_rise & io_da & io_io;
    assign out_data = s_rise & ~io_da & io_io & selected;
    assign tx_load  = out_data & (~tx_valid | tx_ready);
    assign tx_drop  = out_data & ~tx_load;

    assign in_data  = io_e & ~io_da & ~io_io & selected;
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_FULL);
    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = e_fall & rd_q & ~rx_empty;

`ifdef JIO_STATUS_EN
    logic       st_q;
    logic [7:0] status_byte;

    assign in_status   = io_e & io_da & ~io_io & selected;
    assign status_clr  = e_fall & st_q;
    assign status_byte = {~rx_empty, tx_valid, ovf, rx_full, 4'b0000};

    // Remember whether the cycle before an io_e fall was a status read.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) st_q <= 1'b0;
        else       st_q <= in_status;
    end
`else
    assign in_status  = 1'b0;
    assign status_clr = 1'b0;
`endif

    // Strobe history for edge detection, plus the decoded IN Data qualifier
    // that the pop on e_fall is judged against.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s_q  <= 1'b0;
            e_q  <= 1'b0;
            wake <= 1'b1;
            rd_q <= 1'b0;
        end else begin
            s_q  <= io_s;
            e_q  <= io_e;
            wake <= 1'b0;
            rd_q <= in_data;
        end
    end

    // Device address is written by every instance, selected or not.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)         dev_addr <= 8'hFF;
        else if (out_addr) dev_addr <= bus_in;
    end

    // TX holding register: reload wins over a same-cycle handshake.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (tx_load) begin
            tx_valid <= 1'b1;
            tx_data  <= bus_in;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    // Sticky overflow for dropped OUT Data bytes; only a status read clears it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)           ovf <= 1'b0;
        else if (tx_drop)    ovf <= 1'b1;
        else if (status_clr) ovf <= 1'b0;
    end

    // RX FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[wr_ptr] <= rx_data;
    end

    // RX FIFO pointers and occupancy; push and pop together leave count alone.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (rx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Bus drive: FIFO head (or zero when empty) for IN Data, status for IN Addr.
    always_comb begin
        bus_oe  = 1'b0;
        bus_out = 8'h00;
        if (in_data) begin
            bus_oe  = 1'b1;
            bus_out = rx_empty ? 8'h00 : rx_mem[rd_ptr];
        end
`ifdef JIO_STATUS_EN
        else if (in_status) begin
            bus_oe  = 1'b1;
            bus_out = status_byte;
        end
`endif
    end

endmodule

// File: tb/tb_jio_port.sv
// tb_jio_port: randomized bench for jio_port with a transaction-level model.
// The model keeps the device address, TX register, overflow flag and the RX
// FIFO as a queue, updated once per clock edge from the transactions issued.
// Status reads are exercised when JIO_STATUS_EN is defined.
module tb_jio_port;

    localparam logic [7:0] DEV    = 8'h00;
    localparam int         DEPTH  = 4;

    logic       CLK = 1'b0;
    logic       reset;
    logic       io_s, io_e, io_da, io_io;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       selected;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    jio_port #(.DEV_ID(DEV), .RX_DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .io_s     (io_s),
        .io_e     (io_e),
        .io_da    (io_da),
        .io_io    (io_io),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .selected (selected),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 CLK = ~CLK;

    int testsRun    = 0;
    int testsFailed = 0;

    // reference model state
    logic [7:0] mDevAddr;
    logic       mTxValid;
    logic [7:0] mTxData;
    logic       mOvf;
    logic [7:0] mFifo[$];

    // transactions taking effect at the next clock edge
    logic       evAddr, evData, evPop, evStClr;
    logic [7:0] evVal;

    logic rxRand, txRand;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic mSel();
        return mDevAddr == DEV;
    endfunction

    task automatic modelReset();
        mDevAddr = 8'hFF;
        mTxValid = 1'b0;
        mTxData  = 8'h00;
        mOvf     = 1'b0;
        mFifo.delete();
        evAddr = 0; evData = 0; evPop = 0; evStClr = 0;
    endtask

    // one clock edge applied to the model, using the inputs present at that edge
    task automatic modelEdge();
        logic pushOk, accept, drop;
        pushOk = rx_valid && (mFifo.size() < DEPTH);
        if (evPop && mFifo.size() > 0) void'(mFifo.pop_front());
        if (pushOk) mFifo.push_back(rx_data);
        accept = evData && mSel() && (!mTxValid || tx_ready);
        drop   = evData && mSel() && !accept;
        if (accept) begin
            mTxValid = 1'b1;
            mTxData  = evVal;
        end else if (mTxValid && tx_ready) begin
            mTxValid = 1'b0;
        end
        if (drop) mOvf = 1'b1;
        else if (evStClr) mOvf = 1'b0;
        if (evAddr) mDevAddr = evVal;
        evAddr = 0; evData = 0; evPop = 0; evStClr = 0;
    endtask

    task automatic tick();
        if (rxRand) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
        end
        if (txRand) tx_ready = 1'($urandom_range(0, 1));
        @(posedge CLK);
        modelEdge();
        #1;
        checkOutput("selected", selected, mSel());
        checkOutput("tx_valid", tx_valid, mTxValid);
        if (mTxValid) checkOutput("tx_data", tx_data, mTxData);
        checkOutput("rx_ready", rx_ready, mFifo.size() < DEPTH);
    endtask

    task automatic applyStimulus(input logic isAddr, input logic [7:0] v, input int len);
        io_s = 1'b1; io_da = isAddr; io_io = 1'b1; bus_in = v;
        evVal = v;
        if (isAddr) evAddr = 1'b1; else evData = 1'b1;
        for (int i = 0; i < len; i++) tick();
        io_s = 1'b0;
        tick();
    endtask

    task automatic inData(input int len);
        logic [7:0] expOut;
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        for (int i = 0; i < len; i++) begin
            #1;
            expOut = (mSel() && mFifo.size() > 0) ? mFifo[0] : 8'h00;
            checkOutput("in_oe", bus_oe, mSel());
            checkOutput("in_data", bus_out, expOut);
            tick();
        end
        io_e  = 1'b0;
        evPop = mSel();
        tick();
        checkOutput("idle_oe", bus_oe, 1'b0);
    endtask

`ifdef JIO_STATUS_EN
    task automatic inStatus(input int len);
        logic [7:0] expSt;
        io_da = 1'b1; io_io = 1'b0; io_e = 1'b1;
        for (int i = 0; i < len; i++) begin
            #1;
            expSt = mSel() ? {mFifo.size() > 0, mTxValid, mOvf, mFifo.size() == DEPTH, 4'b0000}
                           : 8'h00;
            checkOutput("st_oe", bus_oe, mSel());
            checkOutput("st_byte", bus_out, expSt);
            tick();
        end
        io_e    = 1'b0;
        evStClr = mSel();
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1;
        io_s = 0; io_e = 0; io_da = 0; io_io = 0; bus_in = 0;
        rx_data = 0; rx_valid = 0; tx_ready = 0;
        rxRand = 0; txRand = 0;
        modelReset();
        @(posedge CLK); @(posedge CLK); #1;
        checkOutput("rst_sel", selected, 1'b0);
        checkOutput("rst_txv", tx_valid, 1'b0);
        checkOutput("rst_txd", tx_data, 8'h00);
        checkOutput("rst_rdy", rx_ready, 1'b1);
        checkOutput("rst_oe", bus_oe, 1'b0);
        checkOutput("rst_out", bus_out, 8'h00);
        reset = 1'b0;
        tick();

        // address decode
        applyStimulus(1'b1, 8'h00, 2);
        checkOutput("sel_00", selected, 1'b1);
        applyStimulus(1'b1, 8'h05, 3);
        checkOutput("sel_05", selected, 1'b0);
        applyStimulus(1'b1, 8'h00, 1);

        // TX accept, overflow drop, handshake
        applyStimulus(1'b0, 8'h2A, 3);
        checkOutput("tx_first", tx_data, 8'h2A);
        applyStimulus(1'b0, 8'h11, 2);
        checkOutput("tx_kept", tx_data, 8'h2A);
`ifdef JIO_STATUS_EN
        inStatus(2);
        inStatus(1);
`endif
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checkOutput("tx_done", tx_valid, 1'b0);

        // fill FIFO, drain four reads, read once more from empty
        for (int i = 1; i <= 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        tick();
        checkOutput("full_rdy", rx_ready, 1'b0);
        for (int i = 0; i < 5; i++) inData(3);
        checkOutput("drained", rx_ready, 1'b1);

        // unselected read must not drive or pop
        rx_valid = 1'b1; rx_data = 8'h9C; tick();
        rx_valid = 1'b0;
        applyStimulus(1'b1, 8'h05, 1);
        inData(2);
        applyStimulus(1'b1, 8'h00, 1);
        inData(1);

        // full FIFO with rx_valid held during a pop
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'h40 + 8'(i);
            tick();
        end
        rx_data = 8'h55;
        inData(2);
        checkOutput("pop_rdy", rx_ready, 1'b1);
        tick();
        checkOutput("refill", rx_ready, 1'b0);
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) inData(1);

        // randomized traffic
        rxRand = 1; txRand = 1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0:       applyStimulus(1'b1, ($urandom_range(0, 3) == 0) ? 8'h05 : 8'h00,
                                       $urandom_range(1, 3));
                1, 2:    applyStimulus(1'b0, 8'($urandom), $urandom_range(1, 3));
                3, 4:    inData($urandom_range(1, 3));
`ifdef JIO_STATUS_EN
                5:       inStatus($urandom_range(1, 2));
`endif
                default: tick();
            endcase
        end
        rxRand = 0; txRand = 0;
        rx_valid = 0; tx_ready = 0;
        tick();

        // reset during an OUT Data strobe, release with an OUT Addr strobe held high
        applyStimulus(1'b1, 8'h00, 1);
        io_s = 1'b1; io_da = 1'b0; io_io = 1'b1; bus_in = 8'h77;
        evVal = 8'h77; evData = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        checkOutput("mid_txv", tx_valid, 1'b0);
        checkOutput("mid_rdy", rx_ready, 1'b1);
        @(posedge CLK); @(posedge CLK); #1;
        io_da = 1'b1; bus_in = 8'h00;
        modelReset();
        reset = 1'b0;
        tick();
        tick();
        io_s = 1'b0;
        tick();
        checkOutput("no_spur", selected, 1'b0);
        applyStimulus(1'b1, 8'h00, 1);
        applyStimulus(1'b0, 8'h5A, 1);
        checkOutput("post_rst", tx_data, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
